// File: rtl/ws2811_pkg.sv
// Shared definitions for the WS2811 frame scheduler.
//   CLKS_PER_BIT / BITS_PER_LED : driver bit timing; their product is the per-LED cost
//   MAX_LEDS                    : LEDs per bank
//   state_t                     : scheduler FSM encoding
//   clamp_leds()                : limits a requested LED count to one bank
package ws2811_pkg;

    localparam int CLKS_PER_BIT     = 25;
    localparam int BITS_PER_LED     = 24;
    localparam int MAX_LEDS         = 256;
    localparam int CLKS_PER_LED_DEF = CLKS_PER_BIT * BITS_PER_LED;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } state_t;

    function automatic logic [8:0] clamp_leds(input logic [8:0] req);
        return (req > 9'(MAX_LEDS)) ? 9'(MAX_LEDS) : req;
    endfunction

endpackage

// File: rtl/ws2811_frame_sched_if.sv
// Scheduler bundle: host-side configuration/swap handshake and driver-side launch signals.
//   master : the scheduler (drives swap_ack, back_bank, start, bank, leds, busy, missed)
//   slave  : host software + pixel driver (drive enable, cfg_leds, swap_req)
interface ws2811_frame_sched_if;

    logic        enable;
    logic [8:0]  cfg_leds;
    logic        swap_req;
    logic        swap_ack;
    logic        back_bank;
    logic        start;
    logic        bank;
    logic [8:0]  leds;
    logic        busy;
    logic [15:0] missed;

    modport master (
        input  enable, cfg_leds, swap_req,
        output swap_ack, back_bank, start, bank, leds, busy, missed
    );

    modport slave (
        output enable, cfg_leds, swap_req,
        input  swap_ack, back_bank, start, bank, leds, busy, missed
    );

endinterface

// File: rtl/ws2811_frame_sched_timer.sv
// Frame tick generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_enable   : 0 holds the count at 0 and suppresses the tick
//   o_tick     : high during the wrap cycle of the 0..FRAME_DIV-1 count
module ws2811_frame_sched_timer #(
    parameter int FRAME_DIV = 333333
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_enable && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_enable || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ws2811_frame_sched.sv
// WS2811 frame scheduler: periodic launches to the pixel driver with double-buffered banks.
//   clk, rst_n : 20 MHz clock shared with the driver, asynchronous active-low reset
//   bus        : ws2811_frame_sched_if.master (enable/cfg_leds/swap_req in,
//                swap_ack/back_bank/start/bank/leds/busy/missed out)
//
//   state  | meaning
//   IDLE   | waiting for a frame tick; swaps banks and picks the LED count
//   LAUNCH | latch leds, pulse start, load the transmit + latch-gap budget
//   BUSY   | driver transmitting or in latch gap; counts the budget down to 0
module ws2811_frame_sched
    import ws2811_pkg::*;
#(
    parameter int FRAME_DIV    = 333333,
    parameter int CLKS_PER_LED = CLKS_PER_LED_DEF,
    parameter int RESET_CLKS   = 1024,
    parameter bit REFRESH      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ws2811_frame_sched_if.master  bus
);

    state_t      r_state;
    logic        r_swap_pend;
    logic [8:0]  r_n;
    logic [19:0] r_busy_cnt;
    logic        r_start;
    logic        r_swap_ack;
    logic        r_bank;
    logic [8:0]  r_leds;
    logic        r_busy;
    logic [15:0] r_missed;

    logic        w_tick;
    logic        w_swap;
    logic [8:0]  w_n;
    logic [19:0] w_busy_load;

    ws2811_frame_sched_timer #(.FRAME_DIV(FRAME_DIV)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (bus.enable),
        .o_tick   (w_tick)
    );

    // A request arriving in the tick cycle is served by that same tick.
    assign w_swap      = r_swap_pend || bus.swap_req;
    assign w_n         = clamp_leds(bus.cfg_leds);
    // Worst case 256*600 + 1024 = 154624 fits in 20 bits.
    assign w_busy_load = 20'(r_n) * 20'(CLKS_PER_LED) + 20'(RESET_CLKS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_swap_pend <= 1'b0;
            r_n         <= '0;
            r_busy_cnt  <= '0;
            r_start     <= 1'b0;
            r_swap_ack  <= 1'b0;
            r_bank      <= 1'b0;
            r_leds      <= '0;
            r_busy      <= 1'b0;
            r_missed    <= '0;
        end else begin
            r_start    <= 1'b0;
            r_swap_ack <= 1'b0;

            if (w_tick && (r_state != IDLE) && (r_missed != 16'hFFFF)) begin
                r_missed <= r_missed + 16'd1;
            end

            // Pending swap survives missed ticks; cleared only when a tick takes it.
            if (bus.swap_req) begin
                r_swap_pend <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_tick && (w_swap || REFRESH)) begin
                        if (w_swap) begin
                            r_bank      <= ~r_bank;
                            r_swap_pend <= 1'b0;
                            r_swap_ack  <= 1'b1;
                        end
                        r_n <= w_n;
                        // An empty frame still swaps but never bothers the driver.
                        if (w_n != 9'd0) begin
                            r_state <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    r_leds     <= r_n;
                    r_start    <= 1'b1;
                    r_busy     <= 1'b1;
                    r_busy_cnt <= w_busy_load;
                    r_state    <= BUSY;
                end
                BUSY: begin
                    if (r_busy_cnt == 20'd0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_busy_cnt <= r_busy_cnt - 20'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.start     = r_start;
    assign bus.swap_ack  = r_swap_ack;
    assign bus.bank      = r_bank;
    assign bus.back_bank = ~r_bank;
    assign bus.leds      = r_leds;
    assign bus.busy      = r_busy;
    assign bus.missed    = r_missed;

endmodule

// File: tb/tb_ws2811_frame_sched.sv
// Directed bench for ws2811_frame_sched (FRAME_DIV=2000, RESET_CLKS=1024).
// A second instance with CLKS_PER_LED=25 exercises the full 256-LED busy duration.
module tb_ws2811_frame_sched;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   start_cnt = 0;
    int   ack_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2811_frame_sched_if bus ();
    ws2811_frame_sched_if bus_f ();

    ws2811_frame_sched #(
        .FRAME_DIV(2000), .CLKS_PER_LED(600), .RESET_CLKS(1024), .REFRESH(1'b1)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    ws2811_frame_sched #(
        .FRAME_DIV(2000), .CLKS_PER_LED(25), .RESET_CLKS(1024), .REFRESH(1'b1)
    ) u_fast (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f.master)
    );

    always @(negedge clk) begin
        if (bus.start)    start_cnt <= start_cnt + 1;
        if (bus.swap_ack) ack_cnt   <= ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_start(input string tag, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.start) begin
                at = cyc;
                break;
            end
        end
        chk(tag, bus.start, 1);
    endtask

    task automatic wait_ack(input string tag, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.swap_ack) begin
                at = cyc;
                break;
            end
        end
        chk(tag, bus.swap_ack, 1);
    endtask

    // Called on the negedge where start is seen; returns number of busy-high samples.
    task automatic busy_width(input int budget, input int drop_en_at, output int w);
        w = 0;
        while (bus.busy && w < budget) begin
            w++;
            if (w == drop_en_at) bus.enable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_swap();
        @(negedge clk);
        bus.swap_req = 1'b1;
        @(negedge clk);
        bus.swap_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        int e, t0, t1, t2, t3, t4, ack_at, w, ack_base, st_base, seen_start, seen_busy;

        rst_n          = 1'b0;
        bus.enable     = 1'b0;
        bus.cfg_leds   = 9'd2;
        bus.swap_req   = 1'b0;
        bus_f.enable   = 1'b0;
        bus_f.cfg_leds = 9'd300;
        bus_f.swap_req = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_start",     bus.start, 0);
        chk("rst_swap_ack",  bus.swap_ack, 0);
        chk("rst_busy",      bus.busy, 0);
        chk("rst_bank",      bus.bank, 0);
        chk("rst_back_bank", bus.back_bank, 1);
        chk("rst_leds",      bus.leds, 0);
        chk("rst_missed",    bus.missed, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: refresh launches, latency, busy width, missed tick
        e = cyc;
        bus.enable = 1'b1;
        wait_start("t1_start", 2100, t0);
        chk("t1_latency", t0 - e, 2001);
        chk("t1_bank", bus.bank, 0);
        chk("t1_leds", bus.leds, 2);
        chk("t1_busy_on", bus.busy, 1);
        busy_width(3000, 0, w);
        chk("t1_busy_width", w, 2225);
        wait_start("t1_start2", 4000, t1);
        chk("t1_period", t1 - t0, 4000);
        chk("t1_missed", bus.missed, 1);

        // 2: swap requested while busy waits for the next idle tick
        pulse_swap();
        chk("t2_no_early_flip", bus.bank, 0);
        chk("t2_back_bank_pre", bus.back_bank, 1);
        wait_ack("t2_ack", 5000, ack_at);
        chk("t2_ack_delay", ack_at - t1, 3999);
        chk("t2_bank_flip", bus.bank, 1);
        chk("t2_back_bank", bus.back_bank, 0);
        chk("t2_missed", bus.missed, 2);
        @(negedge clk);
        chk("t2_ack_one_pulse", bus.swap_ack, 0);
        chk("t2_start", bus.start, 1);
        chk("t2_start_bank", bus.bank, 1);
        busy_width(3000, 0, w);
        chk("t2_busy_width", w, 2225);

        // 3: two requests before one tick -> one flip, one ack
        ack_base = ack_cnt;
        pulse_swap();
        repeat (5) @(negedge clk);
        pulse_swap();
        wait_start("t3_start", 2500, t2);
        chk("t3_bank_flip", bus.bank, 0);
        busy_width(3000, 0, w);
        wait_start("t3_start_next", 4000, t3);
        chk("t3_no_double_flip", bus.bank, 0);
        chk("t3_ack_count", ack_cnt - ack_base, 1);
        chk("t3_missed", bus.missed, 4);
        busy_width(3000, 0, w);

        // 4: zero-LED frame with swap: flip + ack but no launch
        bus.cfg_leds = 9'd0;
        st_base = start_cnt;
        pulse_swap();
        wait_ack("t4_ack", 2500, ack_at);
        chk("t4_bank", bus.bank, 1);
        seen_start = 0;
        seen_busy  = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (bus.start) seen_start++;
            if (bus.busy)  seen_busy++;
        end
        chk("t4_no_start", seen_start, 0);
        chk("t4_no_busy", seen_busy, 0);
        chk("t4_start_total", start_cnt - st_base, 0);
        chk("t4_missed", bus.missed, 5);

        // 6a: enable dropped mid-frame; frame completes, nothing new launches
        bus.cfg_leds = 9'd2;
        wait_start("t6a_start", 2100, t4);
        busy_width(3000, 100, w);
        chk("t6a_busy_width", w, 2225);
        seen_start = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.start) seen_start++;
        end
        chk("t6a_no_start", seen_start, 0);
        chk("t6a_busy_low", bus.busy, 0);

        // 5: clamp and full-bank busy duration (per-LED cost 25 clk on u_fast)
        bus_f.enable = 1'b1;
        t0 = -1;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (bus_f.start) begin
                t0 = cyc;
                break;
            end
        end
        chk("t5f_start", bus_f.start, 1);
        chk("t5f_leds", bus_f.leds, 256);
        w = 0;
        while (bus_f.busy && w < 8000) begin
            w++;
            @(negedge clk);
        end
        chk("t5f_busy_width", w, 7425);
        bus_f.enable = 1'b0;

        bus.cfg_leds = 9'd300;
        bus.enable   = 1'b1;
        wait_start("t5_start", 2100, t1);
        chk("t5_leds", bus.leds, 256);
        repeat (50) @(negedge clk);
        chk("t5_busy_mid", bus.busy, 1);

        // 6b: reset mid-frame is immediate and nothing relaunches after release
        rst_n = 1'b0;
        #1;
        chk("t6b_start",     bus.start, 0);
        chk("t6b_swap_ack",  bus.swap_ack, 0);
        chk("t6b_busy",      bus.busy, 0);
        chk("t6b_bank",      bus.bank, 0);
        chk("t6b_back_bank", bus.back_bank, 1);
        chk("t6b_leds",      bus.leds, 0);
        chk("t6b_missed",    bus.missed, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6b_rel_start", bus.start, 0);
        chk("t6b_rel_busy",  bus.busy, 0);
        chk("t6b_rel_leds",  bus.leds, 0);
        chk("t6b_rel_bank",  bus.bank, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
